// File: rtl/led_sequencer.sv
// led_sequencer: multi-channel LED driver with a shared timebase.
// Each channel independently selects off, on, blink or breathe (triangle-ramped
// PWM). All channels share one pattern phase, which sync_i can restart.
//
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   mode_i  - per-channel mode, bits [2i+1:2i] = channel i
//             (00 off, 01 on, 10 blink, 11 breathe)
//   sync_i  - one-cycle pulse restarting all pattern phases
//   led_o   - registered active-high LED drive
//   tick_o  - timebase tick strobe (decode of the prescaler)
module led_sequencer #(
  parameter int unsigned NumLeds        = 4,
  parameter int unsigned CyclesPerTick  = 16_000,
  parameter int unsigned TicksPerToggle = 500,
  parameter int unsigned PwmBits        = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [2*NumLeds-1:0] mode_i,
  input  logic                 sync_i,
  output logic [NumLeds-1:0]   led_o,
  output logic                 tick_o
);

  localparam int unsigned PrescW = (CyclesPerTick > 1) ? $clog2(CyclesPerTick) : 1;
  localparam int unsigned BtcW   = (TicksPerToggle > 1) ? $clog2(TicksPerToggle) : 1;

  localparam logic [PrescW-1:0]  PrescLast = PrescW'(CyclesPerTick - 1);
  localparam logic [BtcW-1:0]    BtcLast   = BtcW'(TicksPerToggle - 1);
  localparam logic [PwmBits-1:0] BrightMax = '1;
  localparam logic [PwmBits-1:0] PwmOne    = PwmBits'(1);

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

  typedef enum logic [1:0] {
    MODE_OFF,
    MODE_ON,
    MODE_BLINK,
    MODE_BREATHE
  } mode_e;

  logic [PrescW-1:0]  presc_q;
  logic [BtcW-1:0]    btc_q;
  logic               blink_q;
  logic [PwmBits-1:0] pwm_q;
  logic [PwmBits-1:0] bright_q;
  dir_e               dir_q;
  logic [NumLeds-1:0] led_q;
  logic [NumLeds-1:0] led_d;
  logic               tick;

  always_comb begin
    tick = (presc_q == PrescLast);
  end

  assign tick_o = tick;
  assign led_o  = led_q;

  // Output select uses the pattern state of the current cycle, so a mode
  // change shows on led_o exactly one cycle later.
  always_comb begin
    led_d = '0;
    for (int unsigned i = 0; i < NumLeds; i++) begin
      unique case (mode_e'(mode_i[2*i +: 2]))
        MODE_OFF:     led_d[i] = 1'b0;
        MODE_ON:      led_d[i] = 1'b1;
        MODE_BLINK:   led_d[i] = blink_q;
        MODE_BREATHE: led_d[i] = (pwm_q < bright_q);
        default:      led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q  <= '0;
      btc_q    <= '0;
      blink_q  <= 1'b0;
      pwm_q    <= '0;
      bright_q <= '0;
      dir_q    <= DIR_UP;
      led_q    <= '0;
    end else begin
      led_q <= led_d;
      // sync_i wins over a coincident tick: no toggle or ramp step that cycle.
      if (sync_i) begin
        presc_q  <= '0;
        btc_q    <= '0;
        blink_q  <= 1'b0;
        pwm_q    <= '0;
        bright_q <= '0;
        dir_q    <= DIR_UP;
      end else begin
        pwm_q   <= pwm_q + PwmOne;
        presc_q <= tick ? '0 : presc_q + PrescW'(1);
        if (tick) begin
          if (btc_q == BtcLast) begin
            btc_q   <= '0;
            blink_q <= ~blink_q;
          end else begin
            btc_q <= btc_q + BtcW'(1);
          end
          // Reflect at the ends so the ramp never wraps.
          unique case (dir_q)
            DIR_UP: begin
              if (bright_q == BrightMax) begin
                bright_q <= BrightMax - PwmOne;
                dir_q    <= DIR_DOWN;
              end else begin
                bright_q <= bright_q + PwmOne;
              end
            end
            DIR_DOWN: begin
              if (bright_q == '0) begin
                bright_q <= PwmOne;
                dir_q    <= DIR_UP;
              end else begin
                bright_q <= bright_q - PwmOne;
              end
            end
            default: dir_q <= DIR_UP;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer with a small timebase
// (CyclesPerTick=4, TicksPerToggle=3, PwmBits=3, NumLeds=4).
module tb_led_sequencer;

  localparam int C    = 4;
  localparam int T    = 3;
  localparam int P    = 3;
  localparam int N    = 4;
  localparam int MAXB = (1 << P) - 1;

  logic         clk;
  logic         rst_n;
  logic [2*N-1:0] mode;
  logic         sync;
  logic [N-1:0] led;
  logic         tick;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  // Reference model state
  int   m_presc, m_btc, m_pwm, m_bright;
  bit   m_blink, m_down;
  logic [N-1:0] m_led;

  logic [N-1:0] exp_q[$];

  led_sequencer #(
    .NumLeds(N),
    .CyclesPerTick(C),
    .TicksPerToggle(T),
    .PwmBits(P)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .mode_i(mode),
    .sync_i(sync),
    .led_o(led),
    .tick_o(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_presc  = 0;
    m_btc    = 0;
    m_pwm    = 0;
    m_bright = 0;
    m_blink  = 0;
    m_down   = 0;
    m_led    = '0;
  endtask

  function automatic logic [N-1:0] led_fn();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      case (mode[2*i +: 2])
        2'b00: r[i] = 1'b0;
        2'b01: r[i] = 1'b1;
        2'b10: r[i] = m_blink;
        default: r[i] = (m_pwm < m_bright);
      endcase
    end
    return r;
  endfunction

  task automatic model_step();
    logic [N-1:0] nl;
    bit t;
    nl = led_fn();
    t  = (m_presc == C - 1);
    if (sync) begin
      m_presc = 0; m_btc = 0; m_blink = 0; m_pwm = 0; m_bright = 0; m_down = 0;
    end else begin
      m_pwm   = (m_pwm + 1) % (1 << P);
      m_presc = t ? 0 : m_presc + 1;
      if (t) begin
        if (m_btc == T - 1) begin
          m_btc   = 0;
          m_blink = !m_blink;
        end else begin
          m_btc = m_btc + 1;
        end
        if (!m_down) begin
          if (m_bright == MAXB) begin m_bright = MAXB - 1; m_down = 1; end
          else m_bright = m_bright + 1;
        end else begin
          if (m_bright == 0) begin m_bright = 1; m_down = 0; end
          else m_bright = m_bright - 1;
        end
      end
    end
    m_led = nl;
  endtask

  // One clock: check tick decode, push expected led, advance, pop and compare.
  task automatic cyc();
    logic [N-1:0] e;
    chk("tick", {31'd0, tick}, {31'd0, (m_presc == C - 1)});
    model_step();
    exp_q.push_back(m_led);
    @(posedge clk);
    #1;
    k++;
    e = exp_q.pop_front();
    chk("led", {28'd0, led}, {28'd0, e});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    mode  = '0;
    sync  = 1'b0;
    model_reset();
    #12;
    chk("reset_led", {28'd0, led}, 32'd0);
    chk("reset_tick", {31'd0, tick}, 32'd0);
    rst_n = 1'b1;

    // Idle after release: LEDs dark, tick every C cycles.
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("t1_led_off", {28'd0, led}, 32'd0);
    end

    // Static on, then off, one cycle latency.
    mode = 8'b00_00_00_01;
    cyc();
    chk("t2_on", {28'd0, led}, 32'd1);
    mode = 8'b00_00_00_00;
    cyc();
    chk("t2_off", {28'd0, led}, 32'd0);

    // Blink on channel 1 from reset.
    mode = 8'b00_00_10_00;
    do_reset();
    for (int i = 0; i < 26; i++) begin
      cyc();
      if (k == 12) chk("t3_low12", {31'd0, led[1]}, 32'd0);
      if (k == 13) chk("t3_high13", {31'd0, led[1]}, 32'd1);
      if (k == 24) chk("t3_high24", {31'd0, led[1]}, 32'd1);
      if (k == 25) chk("t3_low25", {31'd0, led[1]}, 32'd0);
    end

    // Breathe on channel 2 over more than a full ramp.
    mode = 8'b00_11_00_00;
    for (int i = 0; i < 70; i++) cyc();

    // sync_i coincident with a tick while btc=2.
    mode = 8'b00_11_10_01;
    do_reset();
    for (int g = 0; g < 100 && !(m_presc == C - 1 && m_btc == 2); g++) cyc();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    chk("t5_blink_held", {31'd0, led[1]}, 32'd0);
    n = 0;
    for (int g = 0; g < 30 && !led[1]; g++) begin
      cyc();
      n++;
    end
    chk("t5_toggle_delay", n, 32'd13);

    // Async reset mid-breathe.
    for (int g = 0; g < 200 && !(m_bright == 5 && !m_down); g++) cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_async_led", {28'd0, led}, 32'd0);
    chk("t6_async_tick", {31'd0, tick}, 32'd0);
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("t6_held_led", {28'd0, led}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
